// File: rtl/regfile_pkg.sv
// Shared types and default widths for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } rf_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register pending bits, busy lookups and wb_unexp pulse.
// Optional REGFILE_BYPASS_EN: a same-cycle writeback masks the busy bit on matching read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [ADDR_W-1:0] i_addr_c,
    input  logic              i_wrback,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_issue_addr,
    output logic              o_busy_a,
    output logic              o_busy_b,
    output logic              o_wb_unexp
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;
    logic             r_wb_unexp;

    logic             w_a_in, w_b_in, w_c_in, w_i_in;
    logic [IDX_W-1:0] w_a_idx, w_b_idx, w_c_idx, w_i_idx;
    logic             w_wr_ok, w_iss_ok;
    logic             w_pend_a, w_pend_b;

    assign w_a_in  = 32'(i_addr_a) < 32'(DEPTH);
    assign w_b_in  = 32'(i_addr_b) < 32'(DEPTH);
    assign w_c_in  = 32'(i_addr_c) < 32'(DEPTH);
    assign w_i_in  = 32'(i_issue_addr) < 32'(DEPTH);
    assign w_a_idx = i_addr_a[IDX_W-1:0];
    assign w_b_idx = i_addr_b[IDX_W-1:0];
    assign w_c_idx = i_addr_c[IDX_W-1:0];
    assign w_i_idx = i_issue_addr[IDX_W-1:0];

    assign w_wr_ok  = i_ready & i_wrback & w_c_in;
    assign w_iss_ok = i_ready & i_issue & w_i_in;

    // Issue is applied after writeback: a same-cycle issue belongs to a newer producer.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr_ok) begin
            w_pending_nxt[w_c_idx] = 1'b0;
        end
        if (w_iss_ok) begin
            w_pending_nxt[w_i_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_wb_unexp <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_wb_unexp <= i_ready & i_wrback & (~w_c_in | ~r_pending[w_c_idx]);
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        w_pend_a = r_pending[w_a_idx];
        w_pend_b = r_pending[w_b_idx];
        if (w_wr_ok && (i_addr_c == i_addr_a)) begin
            w_pend_a = w_iss_ok && (i_issue_addr == i_addr_a);
        end
        if (w_wr_ok && (i_addr_c == i_addr_b)) begin
            w_pend_b = w_iss_ok && (i_issue_addr == i_addr_b);
        end
    end
`else
    assign w_pend_a = r_pending[w_a_idx];
    assign w_pend_b = r_pending[w_b_idx];
`endif

    assign o_busy_a   = i_ready & w_a_in & w_pend_a;
    assign o_busy_b   = i_ready & w_b_in & w_pend_b;
    assign o_wb_unexp = r_wb_unexp;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised two-read/one-write register file with sequential clear engine and pending scoreboard.
// Optional REGFILE_BYPASS_EN: forwards DinC to read ports addressing the same-cycle write target.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    output logic [DATA_W-1:0] DoA,
    output logic [DATA_W-1:0] DoB,
    output logic              busyA,
    output logic              busyB,
    input  logic [ADDR_W-1:0] AddrC,
    input  logic [DATA_W-1:0] DinC,
    input  logic              wrback,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              init_busy,
    output logic              wb_unexp
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_state_e        r_state;
    logic [IDX_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic             w_ready;
    logic             w_a_in, w_b_in, w_c_in;
    logic [IDX_W-1:0] w_a_idx, w_b_idx, w_c_idx;
    logic             w_byp_a, w_byp_b;

    assign w_ready = (r_state == READY);
    assign w_a_in  = 32'(AddrA) < 32'(DEPTH);
    assign w_b_in  = 32'(AddrB) < 32'(DEPTH);
    assign w_c_in  = 32'(AddrC) < 32'(DEPTH);
    assign w_a_idx = AddrA[IDX_W-1:0];
    assign w_b_idx = AddrB[IDX_W-1:0];
    assign w_c_idx = AddrC[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= READY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READY: r_state <= READY;
                default: r_state <= CLEAR;
            endcase
        end
    end

    // Clear engine owns the write port while clearing; writebacks are ignored then.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (wrback && w_c_in) begin
                r_mem[w_c_idx] <= DinC;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_byp_a = w_ready & wrback & w_c_in & (AddrC == AddrA);
    assign w_byp_b = w_ready & wrback & w_c_in & (AddrC == AddrB);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    assign DoA = (w_ready && w_a_in) ? (w_byp_a ? DinC : r_mem[w_a_idx]) : '0;
    assign DoB = (w_ready && w_b_in) ? (w_byp_b ? DinC : r_mem[w_b_idx]) : '0;
    assign init_busy = ~w_ready;

    regfile_scoreboard #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .i_ready     (w_ready),
        .i_addr_a    (AddrA),
        .i_addr_b    (AddrB),
        .i_addr_c    (AddrC),
        .i_wrback    (wrback),
        .i_issue     (issue),
        .i_issue_addr(issue_addr),
        .o_busy_a    (busyA),
        .o_busy_b    (busyB),
        .o_wb_unexp  (wb_unexp)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb at DEPTH=16 (REGFILE_BYPASS_EN selects forwarding expectations).
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] AddrA, AddrB, AddrC, issue_addr;
    logic [DATA_W-1:0] DinC;
    logic              wrback, issue;
    logic [DATA_W-1:0] DoA, DoB;
    logic              busyA, busyB, init_busy, wb_unexp;

    int errors = 0;
    int checks = 0;

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .AddrA     (AddrA),
        .AddrB     (AddrB),
        .DoA       (DoA),
        .DoB       (DoB),
        .busyA     (busyA),
        .busyB     (busyB),
        .AddrC     (AddrC),
        .DinC      (DinC),
        .wrback    (wrback),
        .issue     (issue),
        .issue_addr(issue_addr),
        .init_busy (init_busy),
        .wb_unexp  (wb_unexp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        int unexp_seen;
        rst = 1'b1; wrback = 1'b1; AddrC = 5'd3; DinC = 32'hDEAD;
        issue = 1'b0; issue_addr = '0; AddrA = 5'd3; AddrB = 5'd3;
        tick(); tick();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy got=%0b exp=1", init_busy); end
        checks++; if (DoA !== '0) begin errors++; $display("FAIL reset_DoA got=%h exp=0", DoA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_busyA got=%0b exp=0", busyA); end
        checks++; if (wb_unexp !== 1'b0) begin errors++; $display("FAIL reset_wb_unexp got=%0b exp=0", wb_unexp); end
        rst = 1'b0;
        cyc = 0; unexp_seen = 0;
        while (init_busy === 1'b1 && cyc < 64) begin
            cyc++;
            tick();
            if (wb_unexp !== 1'b0) unexp_seen++;
        end
        wrback = 1'b0;
        checks++; if (cyc !== DEPTH) begin errors++; $display("FAIL clear_cycles got=%0d exp=%0d", cyc, DEPTH); end
        checks++; if (unexp_seen !== 0) begin errors++; $display("FAIL clear_wb_unexp got=%0d pulses exp=0", unexp_seen); end
        #1;
        checks++; if (DoA !== '0) begin errors++; $display("FAIL clear_ignored_write DoA got=%h exp=0", DoA); end
        tick();
        checks++; if (wb_unexp !== 1'b0) begin errors++; $display("FAIL post_clear_wb_unexp got=%0b exp=0", wb_unexp); end
    endtask

    task automatic test_basic_write();
        issue = 1'b1; issue_addr = 5'd5; AddrA = 5'd5;
        tick();
        issue = 1'b0;
        #1;
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL issue_busyA got=%0b exp=1", busyA); end
        wrback = 1'b1; AddrC = 5'd5; DinC = 32'h1234;
        tick();
        wrback = 1'b0;
        #1;
        checks++; if (DoA !== 32'h1234) begin errors++; $display("FAIL write_DoA got=%h exp=1234", DoA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL write_busyA got=%0b exp=0", busyA); end
        checks++; if (wb_unexp !== 1'b0) begin errors++; $display("FAIL write_wb_unexp got=%0b exp=0", wb_unexp); end
    endtask

    task automatic test_collision();
        issue = 1'b1; issue_addr = 5'd7; AddrB = 5'd7;
        tick();
        issue = 1'b0;
        #1;
        checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL coll_pre_busyB got=%0b exp=1", busyB); end
        issue = 1'b1; issue_addr = 5'd7; wrback = 1'b1; AddrC = 5'd7; DinC = 32'hA5;
        tick();
        issue = 1'b0; wrback = 1'b0;
        #1;
        checks++; if (DoB !== 32'hA5) begin errors++; $display("FAIL coll_DoB got=%h exp=a5", DoB); end
        checks++; if (busyB !== 1'b1) begin errors++; $display("FAIL coll_busyB got=%0b exp=1", busyB); end
        checks++; if (wb_unexp !== 1'b0) begin errors++; $display("FAIL coll_wb_unexp got=%0b exp=0", wb_unexp); end
    endtask

    task automatic test_unexpected();
        wrback = 1'b1; AddrC = 5'd9; DinC = 32'h99; AddrA = 5'd9;
        tick();
        wrback = 1'b0;
        #1;
        checks++; if (wb_unexp !== 1'b1) begin errors++; $display("FAIL unexp9_pulse got=%0b exp=1", wb_unexp); end
        checks++; if (DoA !== 32'h99) begin errors++; $display("FAIL unexp9_DoA got=%h exp=99", DoA); end
        tick();
        checks++; if (wb_unexp !== 1'b0) begin errors++; $display("FAIL unexp9_width got=%0b exp=0", wb_unexp); end
        wrback = 1'b1; AddrC = 5'd20; DinC = 32'hFFFF;
        issue = 1'b1; issue_addr = 5'd20;
        tick();
        wrback = 1'b0; issue = 1'b0;
        AddrA = 5'd4; AddrB = 5'd5;
        #1;
        checks++; if (wb_unexp !== 1'b1) begin errors++; $display("FAIL unexp20_pulse got=%0b exp=1", wb_unexp); end
        checks++; if (DoA !== '0) begin errors++; $display("FAIL unexp20_entry4 got=%h exp=0", DoA); end
        checks++; if (DoB !== 32'h1234) begin errors++; $display("FAIL unexp20_entry5 got=%h exp=1234", DoB); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL oor_issue_busy4 got=%0b exp=0", busyA); end
        AddrA = 5'd20;
        #1;
        checks++; if (DoA !== '0) begin errors++; $display("FAIL oor_read_DoA got=%h exp=0", DoA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL oor_read_busyA got=%0b exp=0", busyA); end
        tick();
        checks++; if (wb_unexp !== 1'b0) begin errors++; $display("FAIL unexp20_width got=%0b exp=0", wb_unexp); end
    endtask

    task automatic test_bypass();
        AddrA = 5'd2; wrback = 1'b1; AddrC = 5'd2; DinC = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        checks++; if (DoA !== 32'h55) begin errors++; $display("FAIL bypass_DoA got=%h exp=55", DoA); end
`else
        checks++; if (DoA !== '0) begin errors++; $display("FAIL nobypass_DoA got=%h exp=0", DoA); end
`endif
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL bypass_busyA got=%0b exp=0", busyA); end
        tick();
        wrback = 1'b0;
        #1;
        checks++; if (DoA !== 32'h55) begin errors++; $display("FAIL bypass_next_DoA got=%h exp=55", DoA); end
        checks++; if (wb_unexp !== 1'b1) begin errors++; $display("FAIL bypass_wb_unexp got=%0b exp=1", wb_unexp); end
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        issue = 1'b1; issue_addr = 5'd11;
        tick();
        issue = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL midclear_busy got=%0b exp=1", init_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        while (init_busy === 1'b1 && cyc < 64) begin
            cyc++;
            tick();
        end
        checks++; if (cyc !== DEPTH) begin errors++; $display("FAIL reclear_cycles got=%0d exp=%0d", cyc, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            AddrA = ADDR_W'(i);
            AddrB = ADDR_W'(DEPTH - 1 - i);
            #1;
            checks++; if (DoA !== '0) begin errors++; $display("FAIL reclear_entry%0d got=%h exp=0", i, DoA); end
            checks++; if (busyA !== 1'b0 || busyB !== 1'b0) begin errors++; $display("FAIL reclear_busy%0d got=%0b%0b exp=00", i, busyA, busyB); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_collision();
        test_unexpected();
        test_bypass();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
